// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the instruction encoder.
//   - opcode constants, instruction word field positions and INSTR_W
//   - encoder FSM state enum and error code constants
//   - fits_s8(): whether a 12-bit signed immediate fits in 8 signed bits
package isa_pkg;

  localparam int INSTR_W = 24;

  // Opcodes (4 bits)
  localparam logic [3:0] OP_MUL  = 4'h0;
  localparam logic [3:0] OP_DIV  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;

  // Word layout: [23:20] opcode, [19:16] rd, [15:12] rn, [11:0] operand
  localparam int OPC_LSB = 20;
  localparam int RD_LSB  = 16;
  localparam int RN_LSB  = 12;
  localparam int OPND_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_IMM      = 2'b11;

  // A 12-bit two's complement value lies in -128..127 exactly when
  // bits [11:7] are all copies of the sign.
  function automatic logic fits_s8(input logic [OPND_W-1:0] v);
    return (v[11:7] == 5'b00000) || (v[11:7] == 5'b11111);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: instruction field stream into the encoder.
//   Handshake: a field set transfers on a rising clk edge where in_valid and
//   in_ready are both high. The master holds fields stable while in_valid is
//   high and not yet accepted; in_ready may depend combinationally on the
//   slave's inputs but never on in_valid.
//   master: drives in_valid, in_opcode, in_rd, in_rn, in_rm, in_imm, in_last
//   slave : drives in_ready
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [3:0]  in_rm;
  logic [11:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_opcode, in_rd, in_rn, in_rm, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rn, in_rm, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational packer for one instruction.
//   Inputs : opcode, rd, rn, rm, imm (12-bit signed)
//   Outputs: word (packed instruction), illegal (opcode not in ISA),
//            imm_oor (immediate does not fit its field)
//   Build option: ENCODER_RANGE_CHECK_EN enables the 8-bit immediate range
//   check; without it immediates are truncated silently and imm_oor stays 0.
//   The 12-bit forms (ldr/str) can never be out of range with a 12-bit input.
module instr_pack
  import isa_pkg::*;
(
  input  logic [3:0]         opcode,
  input  logic [3:0]         rd,
  input  logic [3:0]         rn,
  input  logic [3:0]         rm,
  input  logic [OPND_W-1:0]  imm,
  output logic [INSTR_W-1:0] word,
  output logic               illegal,
  output logic               imm_oor
);

  logic [OPND_W-1:0] operand;

  always_comb begin
    operand = '0;
    illegal = 1'b0;
    imm_oor = 1'b0;
    case (opcode)
      OP_MUL, OP_DIV, OP_ADD, OP_BEQ: operand = {8'h00, rm};
      OP_ADDI, OP_B: begin
        operand = {4'h0, imm[7:0]};
`ifdef ENCODER_RANGE_CHECK_EN
        imm_oor = !fits_s8(imm);
`else
        imm_oor = 1'b0;
`endif
      end
      OP_LDR, OP_STR: operand = imm;
      default: illegal = 1'b1;
    endcase
  end

  assign word = {opcode, rd, rn, operand};

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: checks instruction fields against the ISA, packs them and
// writes them to consecutive instruction-memory addresses from base_addr.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, base_addr  : begin/restart a load at base_addr (any state)
//   fields            : instruction field stream (instr_encoder_if.slave)
//   imem_we/addr/wdata: one-cycle write strobe, address and packed word
//   busy              : state is RUN
//   done              : one-cycle pulse in the cycle of the last write
//   err, err_code     : sticky error and its cause (01 opcode, 10 overflow,
//                       11 immediate range)
//   count             : words written in the current load
//   state             : FSM state, exported for observation
//   Build option: ENCODER_RANGE_CHECK_EN (see instr_pack).
//   INSTR_W is fixed by the ISA; it is a parameter only for port sizing.
module instr_encoder #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  instr_encoder_if.slave       fields,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0]   imem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ADDR_W:0]      count,
  output isa_pkg::state_t      state
);
  import isa_pkg::*;

  logic [ADDR_W-1:0]  ptr;
  logic               wrap;   // pointer has wrapped past all-ones
  logic [INSTR_W-1:0] packed_word;
  logic               illegal;
  logic               imm_oor;
  logic               accept;

  instr_pack u_pack (
    .opcode  (fields.in_opcode),
    .rd      (fields.in_rd),
    .rn      (fields.in_rn),
    .rm      (fields.in_rm),
    .imm     (fields.in_imm),
    .word    (packed_word),
    .illegal (illegal),
    .imm_oor (imm_oor)
  );

  // start takes priority over a simultaneous field set, so it masks ready.
  assign fields.in_ready = (state == ST_RUN) && !start;
  assign accept          = fields.in_valid && fields.in_ready;
  assign busy            = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      wrap       <= 1'b0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        state    <= ST_RUN;
        ptr      <= base_addr;
        wrap     <= 1'b0;
        count    <= '0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end else begin
        case (state)
          ST_RUN: begin
            if (accept) begin
              // Check priority: opcode, then overflow, then immediate.
              if (illegal) begin
                state    <= ST_ERR;
                err      <= 1'b1;
                err_code <= ERR_OPCODE;
              end else if (wrap) begin
                state    <= ST_ERR;
                err      <= 1'b1;
                err_code <= ERR_OVERFLOW;
              end else if (imm_oor) begin
                state    <= ST_ERR;
                err      <= 1'b1;
                err_code <= ERR_IMM;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= ptr;
                imem_wdata <= packed_word;
                ptr        <= ptr + 1'b1;
                count      <= count + 1'b1;
                if (&ptr) wrap <= 1'b1;
                if (fields.in_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: ;  // IDLE and ERR wait for start
        endcase
      end
    end
  end

endmodule
